// File: rtl/crop_pkg.sv
// Shared definitions for the crop frame scheduler: default geometry, FSM encoding
// and a small width helper.
package crop_pkg;

    localparam int DEF_PIXEL_BIT_WIDTH  = 12;
    localparam int DEF_IN_ROWS          = 40;
    localparam int DEF_IN_COLS          = 40;
    localparam int DEF_OUT_ROWS         = 20;
    localparam int DEF_OUT_COLS         = 20;
    localparam int DEF_IMG_ROW_BITWIDTH = 10;
    localparam int DEF_IMG_COL_BITWIDTH = 10;
    localparam int DEF_BOX_FIFO_DEPTH   = 4;

    localparam int FRAME_PIXELS = DEF_IN_ROWS * DEF_IN_COLS;

    typedef enum logic [1:0] {
        ST_ARM    = 2'd0,
        ST_IDLE   = 2'd1,
        ST_LOAD   = 2'd2,
        ST_STREAM = 2'd3
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/crop_box_fifo.sv
// Small synchronous FIFO holding queued crop boxes; the head word is visible on
// o_data whenever the FIFO is non-empty (first-word-fall-through).
module crop_box_fifo
    import crop_pkg::*;
#(
    parameter int WIDTH = DEF_IMG_ROW_BITWIDTH + DEF_IMG_COL_BITWIDTH,
    parameter int DEPTH = DEF_BOX_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/crop_frame_scheduler.sv
// Re-arms the crop filter before every frame, hands it one queued crop box over
// the Y1/X1 streams, then gates exactly one frame of pixels through to it.
module crop_frame_scheduler
    import crop_pkg::*;
#(
    parameter int PIXEL_BIT_WIDTH  = DEF_PIXEL_BIT_WIDTH,
    parameter int IN_ROWS          = DEF_IN_ROWS,
    parameter int IN_COLS          = DEF_IN_COLS,
    parameter int OUT_ROWS         = DEF_OUT_ROWS,
    parameter int OUT_COLS         = DEF_OUT_COLS,
    parameter int IMG_ROW_BITWIDTH = DEF_IMG_ROW_BITWIDTH,
    parameter int IMG_COL_BITWIDTH = DEF_IMG_COL_BITWIDTH,
    parameter int BOX_FIFO_DEPTH   = DEF_BOX_FIFO_DEPTH
) (
    input  logic                                       clk,
    input  logic                                       reset_n,
    input  logic [IMG_ROW_BITWIDTH+IMG_COL_BITWIDTH-1:0] box_in_TDATA,
    input  logic                                       box_in_TVALID,
    output logic                                       box_in_TREADY,
    output logic                                       box_err,
    input  logic [PIXEL_BIT_WIDTH-1:0]                 pixel_in_TDATA,
    input  logic                                       pixel_in_TVALID,
    output logic                                       pixel_in_TREADY,
    output logic [PIXEL_BIT_WIDTH-1:0]                 pixel_out_TDATA,
    output logic                                       pixel_out_TVALID,
    input  logic                                       pixel_out_TREADY,
    output logic [IMG_ROW_BITWIDTH-1:0]                crop_Y1_TDATA,
    output logic                                       crop_Y1_TVALID,
    input  logic                                       crop_Y1_TREADY,
    output logic [IMG_COL_BITWIDTH-1:0]                crop_X1_TDATA,
    output logic                                       crop_X1_TVALID,
    input  logic                                       crop_X1_TREADY,
    output logic                                       filter_rst,
    output logic                                       frame_done,
    output logic [15:0]                                frame_count,
    output logic                                       busy,
    output state_t                                     dbg_state
);

    localparam int R    = IMG_ROW_BITWIDTH;
    localparam int C    = IMG_COL_BITWIDTH;
    localparam int NPIX = IN_ROWS * IN_COLS;
    localparam int CW   = $clog2(NPIX);
    localparam int KW   = max_int(R, C) + 1;

    localparam logic [KW-1:0] Y_LIMIT  = KW'(IN_ROWS - OUT_ROWS);
    localparam logic [KW-1:0] X_LIMIT  = KW'(IN_COLS - 1 - OUT_COLS);
    localparam logic [CW-1:0] LAST_PIX = CW'(NPIX - 1);

    // All streams use AXIS semantics: a beat transfers on a rising clk edge where
    // TVALID and TREADY are both high; TVALID never depends on TREADY.

    state_t         r_state;
    state_t         w_next_state;
    logic           r_filter_rst;
    logic           r_y_valid;
    logic           r_x_valid;
    logic           r_box_err;
    logic           r_frame_done;
    logic [R-1:0]   r_y_hold;
    logic [C-1:0]   r_x_hold;
    logic [CW-1:0]  r_pix_cnt;
    logic [15:0]    r_frame_count;

    logic           w_box_hs;
    logic           w_in_range;
    logic           w_fifo_push;
    logic           w_fifo_pop;
    logic           w_fifo_full;
    logic           w_fifo_empty;
    logic [R+C-1:0] w_head;
    logic [KW-1:0]  w_y_ext;
    logic [KW-1:0]  w_x_ext;
    logic           w_y_hs;
    logic           w_x_hs;
    logic           w_y_done;
    logic           w_x_done;
    logic           w_stream;
    logic           w_pix_hs;
    logic           w_last_pix;

    assign w_y_ext     = {{(KW-R){1'b0}}, box_in_TDATA[R+C-1:C]};
    assign w_x_ext     = {{(KW-C){1'b0}}, box_in_TDATA[C-1:0]};
    assign w_in_range  = (w_y_ext <= Y_LIMIT) && (w_x_ext <= X_LIMIT);
    assign w_box_hs    = box_in_TVALID && !w_fifo_full;
    assign w_fifo_push = w_box_hs && w_in_range;
    assign w_fifo_pop  = (r_state == ST_IDLE) && !w_fifo_empty;

    crop_box_fifo #(
        .WIDTH (R + C),
        .DEPTH (BOX_FIFO_DEPTH)
    ) u_box_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_fifo_push),
        .i_data  (box_in_TDATA),
        .i_pop   (w_fifo_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // A coordinate is done once its beat has gone or is going on this edge.
    assign w_y_hs   = r_y_valid && crop_Y1_TREADY;
    assign w_x_hs   = r_x_valid && crop_X1_TREADY;
    assign w_y_done = !r_y_valid || crop_Y1_TREADY;
    assign w_x_done = !r_x_valid || crop_X1_TREADY;

    assign w_stream   = (r_state == ST_STREAM);
    assign w_pix_hs   = w_stream && pixel_in_TVALID && pixel_out_TREADY;
    assign w_last_pix = w_pix_hs && (r_pix_cnt == LAST_PIX);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_ARM:    w_next_state = ST_IDLE;
            ST_IDLE:   if (!w_fifo_empty) w_next_state = ST_LOAD;
            ST_LOAD:   if (w_y_done && w_x_done) w_next_state = ST_STREAM;
            ST_STREAM: if (w_last_pix) w_next_state = ST_ARM;
            default:   w_next_state = ST_ARM;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_ARM;
            r_filter_rst <= 1'b1;
        end else begin
            r_state      <= w_next_state;
            r_filter_rst <= (w_next_state == ST_ARM);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_y_valid <= 1'b0;
            r_x_valid <= 1'b0;
            r_y_hold  <= '0;
            r_x_hold  <= '0;
        end else if (w_fifo_pop) begin
            r_y_valid <= 1'b1;
            r_x_valid <= 1'b1;
            r_y_hold  <= w_head[R+C-1:C];
            r_x_hold  <= w_head[C-1:0];
        end else begin
            if (w_y_hs) r_y_valid <= 1'b0;
            if (w_x_hs) r_x_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pix_cnt     <= '0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
            r_box_err     <= 1'b0;
        end else begin
            if (w_pix_hs) r_pix_cnt <= w_last_pix ? '0 : r_pix_cnt + 1'b1;
            r_frame_done  <= w_last_pix;
            r_frame_count <= r_frame_count + {15'd0, w_last_pix};
            r_box_err     <= w_box_hs && !w_in_range;
        end
    end

    assign box_in_TREADY    = !w_fifo_full;
    assign box_err          = r_box_err;
    assign pixel_out_TDATA  = pixel_in_TDATA;
    assign pixel_out_TVALID = w_stream && pixel_in_TVALID;
    assign pixel_in_TREADY  = w_stream && pixel_out_TREADY;
    assign crop_Y1_TDATA    = r_y_hold;
    assign crop_Y1_TVALID   = r_y_valid;
    assign crop_X1_TDATA    = r_x_hold;
    assign crop_X1_TVALID   = r_x_valid;
    assign filter_rst       = r_filter_rst;
    assign frame_done       = r_frame_done;
    assign frame_count      = r_frame_count;
    assign busy             = (r_state != ST_IDLE);
    assign dbg_state        = r_state;

endmodule

// File: tb/tb_crop_frame_scheduler.sv
// Bench for crop_frame_scheduler: random boxes and pixels checked against a
// queue-based model of accepted boxes, frame lengths and pixel order.
module tb_crop_frame_scheduler;
    import crop_pkg::*;

    localparam int PBW     = 12;
    localparam int RW      = 10;
    localparam int CWB     = 10;
    localparam int FRAME_N = 40 * 40;
    localparam int Y_MAX   = 40 - 20;
    localparam int X_MAX   = 40 - 1 - 20;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [RW+CWB-1:0] box_in_TDATA = '0;
    logic              box_in_TVALID = 1'b0;
    logic              box_in_TREADY;
    logic              box_err;
    logic [PBW-1:0]    pixel_in_TDATA = '0;
    logic              pixel_in_TVALID = 1'b0;
    logic              pixel_in_TREADY;
    logic [PBW-1:0]    pixel_out_TDATA;
    logic              pixel_out_TVALID;
    logic              pixel_out_TREADY = 1'b1;
    logic [RW-1:0]     crop_Y1_TDATA;
    logic              crop_Y1_TVALID;
    logic              crop_Y1_TREADY = 1'b1;
    logic [CWB-1:0]    crop_X1_TDATA;
    logic              crop_X1_TVALID;
    logic              crop_X1_TREADY = 1'b1;
    logic              filter_rst;
    logic              frame_done;
    logic [15:0]       frame_count;
    logic              busy;
    state_t            dbg_state;

    crop_frame_scheduler dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .box_in_TDATA     (box_in_TDATA),
        .box_in_TVALID    (box_in_TVALID),
        .box_in_TREADY    (box_in_TREADY),
        .box_err          (box_err),
        .pixel_in_TDATA   (pixel_in_TDATA),
        .pixel_in_TVALID  (pixel_in_TVALID),
        .pixel_in_TREADY  (pixel_in_TREADY),
        .pixel_out_TDATA  (pixel_out_TDATA),
        .pixel_out_TVALID (pixel_out_TVALID),
        .pixel_out_TREADY (pixel_out_TREADY),
        .crop_Y1_TDATA    (crop_Y1_TDATA),
        .crop_Y1_TVALID   (crop_Y1_TVALID),
        .crop_Y1_TREADY   (crop_Y1_TREADY),
        .crop_X1_TDATA    (crop_X1_TDATA),
        .crop_X1_TVALID   (crop_X1_TVALID),
        .crop_X1_TREADY   (crop_X1_TREADY),
        .filter_rst       (filter_rst),
        .frame_done       (frame_done),
        .frame_count      (frame_count),
        .busy             (busy),
        .dbg_state        (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;

    logic [RW+CWB-1:0] exp_box_q[$];
    logic [PBW-1:0]    exp_pix_q[$];

    int m_pix = 0;
    int m_frames = 0;
    int m_rst_run = 0;
    bit m_loaded = 0;
    bit m_y_done = 0;
    bit m_x_done = 0;
    bit m_done_due = 0;

    int src_left = 0;
    bit rand_vld = 0;
    bit rand_rdy = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- monitor / reference model ----------------
    always @(negedge clk) begin
        if (!reset_n) begin
            m_pix      = 0;
            m_frames   = 0;
            m_loaded   = 0;
            m_y_done   = 0;
            m_x_done   = 0;
            m_done_due = 0;
            m_rst_run  = 0;
        end else begin
            logic              hs_in;
            logic              hs_out;
            logic              due;
            logic [RW+CWB-1:0] head;
            due        = m_done_due;
            m_done_due = 0;
            if (due || frame_done) check("frame_done", frame_done, due);
            if (due) begin
                check("frame_count", frame_count, m_frames & 16'hFFFF);
                check("rst_with_done", filter_rst, 1);
            end
            if (filter_rst) m_rst_run++;
            else if (m_rst_run != 0) begin
                check("filter_rst_len", m_rst_run, 1);
                m_rst_run = 0;
            end

            hs_in  = pixel_in_TVALID && pixel_in_TREADY;
            hs_out = pixel_out_TVALID && pixel_out_TREADY;
            if (hs_in || hs_out) check("pix_hs_pair", hs_out, hs_in);
            if (hs_out) begin
                check("pix_after_load", m_loaded, 1);
                if (exp_pix_q.size() == 0) check("pix_unexpected", 1, 0);
                else check("pix_data", pixel_out_TDATA, exp_pix_q.pop_front());
                m_pix++;
                if (m_pix == FRAME_N) begin
                    m_pix      = 0;
                    m_loaded   = 0;
                    m_frames++;
                    m_done_due = 1;
                end
            end

            if (crop_Y1_TVALID && crop_Y1_TREADY) begin
                if (exp_box_q.size() == 0 || m_y_done) check("crop_y_unexpected", 1, 0);
                else begin
                    head = exp_box_q[0];
                    check("crop_y", crop_Y1_TDATA, head[RW+CWB-1:CWB]);
                    m_y_done = 1;
                end
            end
            if (crop_X1_TVALID && crop_X1_TREADY) begin
                if (exp_box_q.size() == 0 || m_x_done) check("crop_x_unexpected", 1, 0);
                else begin
                    head = exp_box_q[0];
                    check("crop_x", crop_X1_TDATA, head[CWB-1:0]);
                    m_x_done = 1;
                end
            end
            if (m_y_done && m_x_done) begin
                void'(exp_box_q.pop_front());
                m_y_done = 0;
                m_x_done = 0;
                m_loaded = 1;
            end
        end
    end

    // ---------------- pixel source / sink driver ----------------
    initial begin
        bit acc;
        forever begin
            @(negedge clk);
            acc = pixel_in_TVALID && pixel_in_TREADY;
            @(posedge clk);
            #1;
            if (acc) begin
                pixel_in_TVALID = 1'b0;
                if (src_left > 0) src_left--;
            end
            pixel_out_TREADY = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (!pixel_in_TVALID && src_left > 0 && (!rand_vld || $urandom_range(0, 3) != 0)) begin
                pixel_in_TDATA  = PBW'($urandom);
                pixel_in_TVALID = 1'b1;
                exp_pix_q.push_back(pixel_in_TDATA);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_box(input int y, input int x);
        int t;
        bit ok;
        t  = 0;
        ok = (y <= Y_MAX) && (x <= X_MAX);
        while (!box_in_TREADY && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!box_in_TREADY) begin
            check("box_tready_timeout", 0, 1);
            return;
        end
        box_in_TDATA  = {RW'(y), CWB'(x)};
        box_in_TVALID = 1'b1;
        if (ok) exp_box_q.push_back({RW'(y), CWB'(x)});
        @(posedge clk);
        #1;
        box_in_TVALID = 1'b0;
        @(negedge clk);
        check("box_err", box_err, ok ? 0 : 1);
        @(negedge clk);
        check("box_err_clear", box_err, 0);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int t;
        t = 0;
        while (m_frames < target && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("frames_reached", (m_frames >= target) ? 1 : 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        check("rst_filter_rst", filter_rst, 1);
        check("rst_crop_y_valid", crop_Y1_TVALID, 0);
        check("rst_crop_x_valid", crop_X1_TVALID, 0);
        check("rst_box_tready", box_in_TREADY, 1);
        check("rst_box_err", box_err, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_pix_tready", pixel_in_TREADY, 0);
        check("rst_pix_tvalid", pixel_out_TVALID, 0);
        check("rst_busy", busy, 1);
        check("rst_state", dbg_state, ST_ARM);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("arm_pulse_high", filter_rst, 1);
        @(negedge clk);
        check("arm_pulse_low", filter_rst, 0);
        check("idle_not_busy", busy, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int t;
        logic [31:0] r;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        release_reset();

        // single frame with box (5,3), no backpressure
        push_box(5, 3);
        src_left = FRAME_N;
        wait_frames(1, 5000);
        check("t1_frame_count", frame_count, 1);

        // out-of-range boxes are consumed but never loaded
        push_box(Y_MAX + 1, 0);
        push_box(0, X_MAX + 1);
        repeat (4) @(negedge clk);
        check("t3_idle", busy, 0);
        check("t3_no_load", crop_Y1_TVALID, 0);
        check("t3_fifo_empty", box_in_TREADY, 1);

        // first box goes to the filter, four more fill the queue
        push_box(Y_MAX, X_MAX);
        for (int i = 0; i < 4; i++) begin
            r = $urandom;
            push_box($urandom_range(0, Y_MAX), $urandom_range(0, X_MAX));
        end
        check("t2_full_tready", box_in_TREADY, 0);
        repeat (3) @(negedge clk);
        check("t2_full_tready_hold", box_in_TREADY, 0);
        rand_vld = 1;
        rand_rdy = 1;
        src_left = 5 * FRAME_N;
        wait_frames(6, 40000);
        rand_vld = 0;
        rand_rdy = 0;
        check("t2_frame_count", frame_count, 6);
        check("t2_tready_back", box_in_TREADY, 1);

        // X coordinate held off while Y goes straight through
        crop_X1_TREADY = 1'b0;
        push_box(7, 9);
        src_left = FRAME_N;
        t = 0;
        while (!crop_Y1_TVALID && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("t4_y_valid_seen", crop_Y1_TVALID, 1);
        check("t4_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4_y_dropped", crop_Y1_TVALID, 0);
            check("t4_x_held", crop_X1_TVALID, 1);
            check("t4_pix_stalled", pixel_in_TREADY, 0);
        end
        @(posedge clk);
        #1;
        crop_X1_TREADY = 1'b1;
        wait_frames(7, 5000);

        // asynchronous reset in the middle of a frame
        push_box(0, 0);
        src_left = FRAME_N;
        t = 0;
        while (m_pix < 800 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("t6_reached_800", (m_pix >= 800) ? 1 : 0, 1);
        #1;
        reset_n         = 1'b0;
        src_left        = 0;
        pixel_in_TVALID = 1'b0;
        exp_pix_q.delete();
        exp_box_q.delete();
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        release_reset();
        push_box(11, 13);
        src_left = FRAME_N;
        wait_frames(1, 5000);
        check("t6_frame_count", frame_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
